// File: rtl/radio_align_samples_if.sv
// ============================================================================
// Module   : radio_align_samples_if
// Brief    : Input/config/output bundle for radio_align_samples.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface radio_align_samples_if #(
  parameter int SAMP_W = 8,
  parameter int SPC    = 4,
  parameter int USER_W = 8
);
  localparam int DATA_W = SPC * SAMP_W;
  localparam int SH_W   = $clog2(SPC);

  logic [DATA_W-1:0] i_data;
  logic [USER_W-1:0] i_user;
  logic              i_push;
  logic              i_dir;
  logic [SH_W-1:0]   i_shift;
  logic              i_cfg_en;
  logic [DATA_W-1:0] o_data;
  logic [USER_W-1:0] o_user;

  modport master (
    output i_data, i_user, i_push, i_dir, i_shift, i_cfg_en,
    input  o_data, o_user
  );

  modport slave (
    input  i_data, i_user, i_push, i_dir, i_shift, i_cfg_en,
    output o_data, o_user
  );
endinterface

`default_nettype wire

// File: rtl/radio_align_samples.sv
// ============================================================================
// Module   : radio_align_samples
// Brief    : Whole-sample left/right re-alignment of a multi-sample word
//            stream, stitched from the current and previous pushed words.
//            Define ALIGN_SAMPLES_ASSERT_EN to enable X-check assertions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module radio_align_samples #(
  parameter int SAMP_W   = 8,
  parameter int SPC      = 4,
  parameter int USER_W   = 8,
  parameter int PIPE_IN  = 1,
  parameter int PIPE_OUT = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  radio_align_samples_if.slave  bus
);
  localparam int            DATA_W    = SPC * SAMP_W;
  localparam int            SH_W      = $clog2(SPC);
  localparam logic [SH_W:0] c_SPC_IDX = (SH_W+1)'(SPC);

  logic [DATA_W-1:0] w_data;
  logic [USER_W-1:0] w_user;
  logic              w_push;
  logic              w_cfg_en;
  logic              w_dir;
  logic [SH_W-1:0]   w_shift;

  generate
    if (PIPE_IN != 0) begin : g_pipe_in
      logic [DATA_W-1:0] r_data;
      logic [USER_W-1:0] r_user;
      logic              r_push;
      logic              r_cfg_en;
      logic              r_dir;
      logic [SH_W-1:0]   r_shift;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_data   <= '0;
          r_user   <= '0;
          r_push   <= 1'b0;
          r_cfg_en <= 1'b0;
          r_dir    <= 1'b0;
          r_shift  <= '0;
        end else begin
          r_data   <= bus.i_data;
          r_user   <= bus.i_user;
          r_push   <= bus.i_push;
          r_cfg_en <= bus.i_cfg_en;
          r_dir    <= bus.i_dir;
          r_shift  <= bus.i_shift;
        end
      end

      assign w_data   = r_data;
      assign w_user   = r_user;
      assign w_push   = r_push;
      assign w_cfg_en = r_cfg_en;
      assign w_dir    = r_dir;
      assign w_shift  = r_shift;
    end else begin : g_no_pipe_in
      assign w_data   = bus.i_data;
      assign w_user   = bus.i_user;
      assign w_push   = bus.i_push;
      assign w_cfg_en = bus.i_cfg_en;
      assign w_dir    = bus.i_dir;
      assign w_shift  = bus.i_shift;
    end
  endgenerate

  logic              r_cfg_dir;
  logic [SH_W-1:0]   r_cfg_shift;
  logic [DATA_W-1:0] r_prev;
  logic [DATA_W-1:0] r_last_data;
  logic [USER_W-1:0] r_last_user;

  logic                w_eff_dir;
  logic [SH_W-1:0]     w_eff_shift;
  logic [SH_W:0]       w_idx;
  logic [2*DATA_W-1:0] w_cat;
  logic [DATA_W-1:0]   w_cand [0:SPC];
  logic [DATA_W-1:0]   w_aligned;

  // A config load in the same cycle as a push applies to that push.
  assign w_eff_dir   = w_cfg_en ? w_dir   : r_cfg_dir;
  assign w_eff_shift = w_cfg_en ? w_shift : r_cfg_shift;

  // Every alignment is a SAMP_W-granular window into {C,P}: right s starts at
  // sample s, left s at sample SPC-s, and s==0 selects C (position SPC).
  always_comb begin
    w_idx = c_SPC_IDX;
    if (w_eff_shift != '0) begin
      w_idx = w_eff_dir ? {1'b0, w_eff_shift} : (c_SPC_IDX - {1'b0, w_eff_shift});
    end
  end

  assign w_cat = {w_data, r_prev};

  generate
    for (genvar k = 0; k <= SPC; k++) begin : g_cand
      assign w_cand[k] = w_cat[k*SAMP_W +: DATA_W];
    end
  endgenerate

  assign w_aligned = w_cand[w_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_dir   <= 1'b0;
      r_cfg_shift <= '0;
      r_prev      <= '0;
      r_last_data <= '0;
      r_last_user <= '0;
    end else begin
      if (w_cfg_en) begin
        r_cfg_dir   <= w_dir;
        r_cfg_shift <= w_shift;
      end
      if (w_push) begin
        r_prev      <= w_data;
        r_last_data <= w_aligned;
        r_last_user <= w_user;
      end
    end
  end

  generate
    if (PIPE_OUT != 0) begin : g_pipe_out
      assign bus.o_data = r_last_data;
      assign bus.o_user = r_last_user;
    end else begin : g_no_pipe_out
      // Without an output stage the hold register only covers non-push cycles.
      assign bus.o_data = w_push ? w_aligned : r_last_data;
      assign bus.o_user = w_push ? w_user    : r_last_user;
    end
  endgenerate

`ifdef ALIGN_SAMPLES_ASSERT_EN
  a_push_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown(bus.i_push));
  a_cfg_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown(bus.i_cfg_en));
  a_payload_known: assert property (@(posedge clk) disable iff (rst)
    bus.i_push |-> !$isunknown({bus.i_data, bus.i_user}));
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_radio_align_samples.sv
// ============================================================================
// Module   : tb_radio_align_samples
// Brief    : Self-checking bench for radio_align_samples (scoreboard + directed).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_radio_align_samples;
  localparam int SAMP_W   = 8;
  localparam int SPC      = 4;
  localparam int USER_W   = 8;
  localparam int PIPE_IN  = 1;
  localparam int PIPE_OUT = 1;
  localparam int DATA_W   = SPC * SAMP_W;
  localparam int SH_W     = $clog2(SPC);
  localparam int LAT      = PIPE_IN + PIPE_OUT;
  localparam logic [31:0] A = 32'h03020100;
  localparam logic [31:0] B = 32'h07060504;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  radio_align_samples_if #(.SAMP_W(SAMP_W), .SPC(SPC), .USER_W(USER_W)) bus ();

  radio_align_samples #(
    .SAMP_W(SAMP_W), .SPC(SPC), .USER_W(USER_W),
    .PIPE_IN(PIPE_IN), .PIPE_OUT(PIPE_OUT)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [USER_W-1:0] user;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  exp_t last_exp;
  logic              m_dir;
  logic [SH_W-1:0]   m_shift;
  logic [DATA_W-1:0] m_prev;
  logic [7:0]        hist;

  function automatic logic [DATA_W-1:0] align_model(input logic [DATA_W-1:0] c,
                                                     input logic [DATA_W-1:0] p,
                                                     input logic d, input int s);
    if (s == 0) return c;
    if (d) return (p >> (s*SAMP_W)) | (c << ((SPC-s)*SAMP_W));
    return (c << (s*SAMP_W)) | (p >> ((SPC-s)*SAMP_W));
  endfunction

  task automatic drive(input bit push, input logic [DATA_W-1:0] d,
                       input logic [USER_W-1:0] u, input bit cfg,
                       input bit dir, input logic [SH_W-1:0] sh);
    exp_t e;
    bus.i_push   = push;
    bus.i_data   = d;
    bus.i_user   = u;
    bus.i_cfg_en = cfg;
    bus.i_dir    = dir;
    bus.i_shift  = sh;
    if (cfg) begin
      m_dir   = dir;
      m_shift = sh;
    end
    if (push) begin
      e.data = align_model(d, m_prev, m_dir, int'(m_shift));
      e.user = u;
      sb_q.push_back(e);
      m_prev = d;
    end
    @(posedge clk);
    #1;
    bus.i_push   = 1'b0;
    bus.i_cfg_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, DATA_W'($urandom), USER_W'($urandom), 1'b0, 1'b0, '0);
  endtask

  task automatic monitor();
    logic [8:0] hv;
    exp_t e;
    forever begin
      @(posedge clk);
      hist = rst ? 8'h00 : {hist[6:0], bus.i_push};
      @(negedge clk);
      if (!rst) begin
        hv = {hist, bus.i_push};
        if (hv[LAT]) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow: output word produced with no expected entry at %0t", $time);
          end else begin
            e = sb_q.pop_front();
            last_exp = e;
          end
        end
        checks++;
        if (bus.o_data !== last_exp.data || bus.o_user !== last_exp.user) begin
          failures++;
          $display("FAIL sb_out at %0t: got data=%h user=%h, want data=%h user=%h",
                   $time, bus.o_data, bus.o_user, last_exp.data, last_exp.user);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if (bus.o_data !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h want %h", bus.o_data, 32'h0);
    end
    checks++;
    if (bus.o_user !== '0) begin
      failures++;
      $display("FAIL reset_user: got %h want %h", bus.o_user, 8'h0);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_shift0();
    drive(1'b1, A, 8'h11, 1'b1, 1'b0, 2'd0);
    idle(LAT+1);
    checks++;
    if (bus.o_data !== A || bus.o_user !== 8'h11) begin
      failures++;
      $display("FAIL shift0: got data=%h user=%h want data=%h user=11", bus.o_data, bus.o_user, A);
    end
  endtask

  task automatic test_right1();
    drive(1'b0, '0, '0, 1'b1, 1'b1, 2'd1);
    drive(1'b1, A, 8'h21, 1'b0, 1'b0, '0);
    drive(1'b1, B, 8'h22, 1'b0, 1'b0, '0);
    idle(LAT+1);
    checks++;
    if (bus.o_data !== 32'h04030201 || bus.o_user !== 8'h22) begin
      failures++;
      $display("FAIL right1: got data=%h user=%h want data=04030201 user=22", bus.o_data, bus.o_user);
    end
  endtask

  task automatic test_left1();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 2'd1);
    drive(1'b1, A, 8'h31, 1'b0, 1'b0, '0);
    idle(LAT+1);
    checks++;
    if (bus.o_data[31:8] !== 24'h020100 || bus.o_user !== 8'h31) begin
      failures++;
      $display("FAIL left1_first: got upper=%h user=%h want upper=020100 user=31", bus.o_data[31:8], bus.o_user);
    end
    drive(1'b1, B, 8'h32, 1'b0, 1'b0, '0);
    idle(LAT+1);
    checks++;
    if (bus.o_data !== 32'h06050403) begin
      failures++;
      $display("FAIL left1_second: got %h want 06050403", bus.o_data);
    end
  endtask

  task automatic test_right3_gaps();
    drive(1'b0, '0, '0, 1'b1, 1'b1, 2'd3);
    drive(1'b1, A, 8'h41, 1'b0, 1'b0, '0);
    idle(LAT+3);
    checks++;
    if (bus.o_data !== 32'h02010007) begin
      failures++;
      $display("FAIL right3_stale_hold: got %h want 02010007", bus.o_data);
    end
    drive(1'b1, B, 8'h42, 1'b0, 1'b0, '0);
    idle(LAT+4);
    checks++;
    if (bus.o_data !== 32'h06050403 || bus.o_user !== 8'h42) begin
      failures++;
      $display("FAIL right3: got data=%h user=%h want data=06050403 user=42", bus.o_data, bus.o_user);
    end
  endtask

  task automatic test_random();
    logic            dir;
    logic [SH_W-1:0] sh;
    int              n;
    for (int i = 0; i < 1000; i++) begin
      dir = 1'($urandom_range(0, 1));
      sh  = SH_W'($urandom_range(0, SPC-1));
      n   = $urandom_range(1, 5);
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b1, DATA_W'($urandom), USER_W'($urandom), 1'b1, dir, sh);
        n--;
      end else begin
        drive(1'b0, DATA_W'($urandom), USER_W'($urandom), 1'b1, dir, sh);
      end
      while (n > 0) begin
        if ($urandom_range(0, 1) == 1) begin
          drive(1'b1, DATA_W'($urandom), USER_W'($urandom), 1'b0, 1'b0, '0);
          n--;
        end else begin
          idle(1);
        end
      end
    end
    idle(LAT+1);
  endtask

  task automatic test_reset_mid();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 2'd2);
    drive(1'b1, A, 8'h51, 1'b0, 1'b0, '0);
    rst = 1'b1;
    sb_q.delete();
    last_exp = '0;
    m_prev   = '0;
    m_dir    = 1'b0;
    m_shift  = '0;
    idle(1);
    rst = 1'b0;
    idle(PIPE_OUT);
    checks++;
    if (bus.o_data !== '0 || bus.o_user !== '0) begin
      failures++;
      $display("FAIL reset_mid: got data=%h user=%h want data=0 user=0", bus.o_data, bus.o_user);
    end
    drive(1'b1, B, 8'h52, 1'b1, 1'b1, 2'd1);
    idle(LAT+1);
    checks++;
    if (bus.o_data !== 32'h04000000 || bus.o_user !== 8'h52) begin
      failures++;
      $display("FAIL reset_zero_prev: got data=%h user=%h want data=04000000 user=52", bus.o_data, bus.o_user);
    end
  endtask

  initial begin
    bus.i_data   = '0;
    bus.i_user   = '0;
    bus.i_push   = 1'b0;
    bus.i_dir    = 1'b0;
    bus.i_shift  = '0;
    bus.i_cfg_en = 1'b0;
    last_exp     = '0;
    m_dir        = 1'b0;
    m_shift      = '0;
    m_prev       = '0;
    hist         = '0;
    fork
      monitor();
    join_none
    #1;
    test_reset();
    test_shift0();
    test_right1();
    test_left1();
    test_right3_gaps();
    test_random();
    test_reset_mid();
    idle(LAT+2);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending entries want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
